imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 158 +++++++++++++++
 tb/tb_imem_loader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader
//   Writer side of the single-cycle core's instruction memory. It takes a
//   byte stream over valid/ready and packs each four bytes into a
//   little-endian 32-bit word. Each word is written to byte address
//   index*4. The core is held in reset while loading. It is released once
//   the all-zero halt word has been written.
//
// Ports
//   clk, rst        clock / async active-low reset
//   start           1-cycle pulse; begins a load from IDLE, DONE or ERR
//   in_valid/ready  byte-stream handshake (in_ready registered)
//   in_data         byte-stream data
//   im_we           instruction-memory write strobe (high only in WRITE)
//   im_addr/wdata   write byte address / assembled word (held otherwise)
//   cpu_rst         active-high core reset, low only in DONE
//   done / error    load ended on terminator / ran out of capacity
//   word_count      words written in this load, terminator included
module imem_loader #(
  parameter  int MAX_WORDS = 64,
  localparam int CW        = $clog2(MAX_WORDS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          im_we,
  output logic [31:0]   im_addr,
  output logic [31:0]   im_wdata,
  output logic          cpu_rst,
  output logic          done,
  output logic          error,
  output logic [CW-1:0] word_count
);

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERR} state_t;

  state_t        state_q, state_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [23:0]   word_q, word_d;      // bytes 0..2 of the word in flight
  logic          in_ready_q, in_ready_d;
  logic          im_we_q, im_we_d;
  logic [31:0]   im_addr_q, im_addr_d;
  logic [31:0]   im_wdata_q, im_wdata_d;
  logic          cpu_rst_q, cpu_rst_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [CW-1:0] wc_q, wc_d;
  logic [CW-1:0] wc_inc;

  assign wc_inc = wc_q + CW'(1);

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    in_ready_d = in_ready_q;
    im_we_d    = im_we_q;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    cpu_rst_d  = cpu_rst_q;
    done_d     = done_q;
    error_d    = error_q;
    wc_d       = wc_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_RECV;
          in_ready_d = 1'b1;
          cpu_rst_d  = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          wc_d       = '0;
          byte_idx_d = '0;
        end
      end
      S_RECV: begin
        if (in_valid && in_ready_q) begin
          if (byte_idx_q == 2'd3) begin
            // The fourth byte goes straight into the write register.
            // Ready drops at this edge, so nothing is taken during WRITE.
            state_d    = S_WRITE;
            in_ready_d = 1'b0;
            im_we_d    = 1'b1;
            im_addr_d  = 32'(wc_q) << 2;
            im_wdata_d = {in_data, word_q};
            byte_idx_d = '0;
          end else begin
            case (byte_idx_q)
              2'd0:    word_d[7:0]   = in_data;
              2'd1:    word_d[15:8]  = in_data;
              default: word_d[23:16] = in_data;
            endcase
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        im_we_d    = 1'b0;
        wc_d       = wc_inc;
        byte_idx_d = '0;
        if (im_wdata_q == 32'd0) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          cpu_rst_d = 1'b0;
        end else if (wc_inc == CW'(MAX_WORDS)) begin
          // Memory is full; stopping here bounds word_count and im_addr.
          state_d = S_ERR;
          error_d = 1'b1;
        end else begin
          state_d    = S_RECV;
          in_ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      byte_idx_q <= '0;
      word_q     <= '0;
      in_ready_q <= 1'b0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      wc_q       <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      in_ready_q <= in_ready_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
      wc_q       <= wc_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign im_we      = im_we_q;
  assign im_addr    = im_addr_q;
  assign im_wdata   = im_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int MAXW = 4;
  localparam int CW   = $clog2(MAXW + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, im_we, cpu_rst, done, error;
  logic [31:0]   im_addr, im_wdata;
  logic [CW-1:0] word_count;

  imem_loader #(.MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_rst(cpu_rst), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- model: stream -> expected writes and end state
  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  logic [7:0]  stream_q[$];
  wr_t         exp_q[$];
  logic [31:0] wr_a_log[$];
  logic [31:0] wr_d_log[$];
  bit          exp_done, exp_err;
  int          exp_wc;

  function automatic void build_model();
    logic [31:0] d;
    exp_q.delete();
    exp_done = 0; exp_err = 0; exp_wc = 0;
    for (int w = 0; w * 4 + 3 < stream_q.size(); w++) begin
      d = {stream_q[w*4+3], stream_q[w*4+2], stream_q[w*4+1], stream_q[w*4]};
      exp_q.push_back('{addr: 32'(w * 4), data: d});
      exp_wc = w + 1;
      if (d == 32'd0) begin exp_done = 1; break; end
      if (w + 1 == MAXW) begin exp_err = 1; break; end
    end
  endfunction

  // ---------------- compare process
  always @(negedge clk) begin
    if (rst) begin
      if (im_we) begin
        if (exp_q.size() == 0) chk("unexpected_we", {31'd0, im_we}, 32'd0);
        else begin
          chk("wr_addr", im_addr, exp_q[0].addr);
          chk("wr_data", im_wdata, exp_q[0].data);
          wr_a_log.push_back(im_addr);
          wr_d_log.push_back(im_wdata);
          void'(exp_q.pop_front());
        end
      end
      if (!cpu_rst) chk("cpu_rst_low_only_done", {31'd0, done}, 32'd1);
      if (in_ready) chk("ready_excl_we", {31'd0, im_we}, 32'd0);
    end
  end

  // ---------------- driver
  task automatic send_range(input int lo, input int hi, input bit toggle);
    int  i = lo;
    int  guard = 0;
    bit  ph = 1'b1;
    while (i < hi && guard < 500) begin
      @(negedge clk);
      guard++;
      in_valid = toggle ? ph : 1'b1;
      ph = !ph;
      in_data = stream_q[i];
      if (in_valid && in_ready) i++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("send_timeout", i, hi);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic check_end(input string nm);
    for (int i = 0; i < 200 && !(done || error); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk({nm, "_done"}, {31'd0, done}, {31'd0, exp_done});
    chk({nm, "_error"}, {31'd0, error}, {31'd0, exp_err});
    chk({nm, "_wc"}, 32'(word_count), 32'(exp_wc));
    chk({nm, "_cpu_rst"}, {31'd0, cpu_rst}, {31'd0, !exp_done});
    chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({nm, "_pending"}, exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
    chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({nm, "_im_we"}, {31'd0, im_we}, 32'd0);
    chk({nm, "_im_addr"}, im_addr, 32'd0);
    chk({nm, "_im_wdata"}, im_wdata, 32'd0);
    chk({nm, "_done_err"}, {30'd0, done, error}, 32'd0);
    chk({nm, "_wc"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    // 1: reset held for 3 cycles
    repeat (3) @(negedge clk);
    check_reset_vals("rst_hold");
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_rel");

    // 2: basic load, 0x00000433 then terminator
    stream_q = '{8'h33, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    build_model();
    chk("model_w0", exp_q[0].data, 32'h0000_0433);
    chk("model_n", exp_q.size(), 32'd2);
    wr_a_log.delete(); wr_d_log.delete();
    pulse_start();
    send_range(0, 8, 1'b0);
    check_end("basic");
    chk("lit_n", wr_d_log.size(), 32'd2);
    if (wr_d_log.size() == 2) begin
      chk("lit_d0", wr_d_log[0], 32'h0000_0433);
      chk("lit_a1", wr_a_log[1], 32'h0000_0004);
    end
    chk("lit_wc", 32'(word_count), 32'd2);

    // 3: same load with gapped valid
    build_model();
    pulse_start();
    send_range(0, 8, 1'b1);
    check_end("gapped");

    // 4: capacity exhausted
    stream_q.delete();
    repeat (4) stream_q = {stream_q, 8'h13, 8'h03, 8'h40, 8'h00};
    build_model();
    chk("model_a3", exp_q[3].addr, 32'h0000_000C);
    wr_d_log.delete();
    pulse_start();
    send_range(0, 16, 1'b0);
    check_end("full");
    repeat (10) @(negedge clk);
    chk("full_nwrites", wr_d_log.size(), 32'd4);

    // 5: reset mid-word, then a single terminator load
    stream_q = '{8'hAA, 8'hBB};
    build_model();
    pulse_start();
    send_range(0, 2, 1'b0);
    @(posedge clk); #2 rst = 1'b0;
    #1 check_reset_vals("mid_rst");
    @(negedge clk); rst = 1'b1;
    stream_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    build_model();
    pulse_start();
    send_range(0, 4, 1'b0);
    check_end("after_rst");

    // 6: restart from DONE, start ignored while receiving
    stream_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00};
    build_model();
    chk("model_w0b", exp_q[0].data, 32'h1234_5678);
    pulse_start();
    chk("restart_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("restart_done", {31'd0, done}, 32'd0);
    chk("restart_wc", 32'(word_count), 32'd0);
    chk("restart_ready", {31'd0, in_ready}, 32'd1);
    send_range(0, 2, 1'b0);
    pulse_start();
    chk("recv_start_ready", {31'd0, in_ready}, 32'd1);
    send_range(2, 8, 1'b0);
    check_end("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule
